// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache: address split,
// frame layout and controller state encoding.
package icache_pkg;

    localparam int SETS  = 16;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef logic [31:0] word_t;

    // Fetch address viewed as tag / frame index / byte offset.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [1:0]       bytoff;
    } icachef_t;

    // One cache frame: a single instruction word with its tag.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            data;
    } icache_frame_t;

    typedef enum logic {
        COMPARE = 1'b0,
        FETCH   = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache (SETS one-word frames).
// Hits are combinational in COMPARE; a miss latches the address and
// issues a single-word read until the memory drops iwait, then fills.
// Optional build macro: ICACHE_PERF_EN adds hit_cnt / miss_cnt outputs.
module icache
    import icache_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    icache_frame_t frames [SETS];
    icache_state_t state;
    icachef_t      req;
    icachef_t      miss_addr;
    logic          lookup_hit;
    logic          fill;

    assign req = icachef_t'(imemaddr);

    // Tag compare against the indexed frame; only meaningful while in COMPARE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        lookup_hit = 1'b0;
        if (state == COMPARE && imemREN)
            lookup_hit = frames[req.idx].valid && (frames[req.idx].tag == req.tag);
    end

    // Outputs are forced quiet while reset is asserted, even if a frame still matches.
    assign ihit     = nRST && lookup_hit;
    assign imemload = ihit ? frames[req.idx].data : '0;
    assign iaddr    = miss_addr;
    assign fill     = (state == FETCH) && !iwait;

    // Miss controller: latch the missing address, hold the read until memory responds.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!nRST) begin
            state     <= COMPARE;
            miss_addr <= '0;
            iREN      <= 1'b0;
        end else begin
            case (state)
                COMPARE: begin
                    if (imemREN && !lookup_hit) begin
                        miss_addr <= req;
                        state     <= FETCH;
                        iREN      <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        state <= COMPARE;
                        iREN  <= 1'b0;
                    end
                end
                default: begin
                    state <= COMPARE;
                    iREN  <= 1'b0;
                end
            endcase
        end
    end

    // Frame array: clear valid bits on reset, write the returning word on fill.
    always_ff @(posedge CLK) begin
        // NOTE: only the valid bits are reset; tag/data are don't-care until valid is set.
        if (!nRST) begin
            for (int i = 0; i < SETS; i++)
                frames[i].valid <= 1'b0;
        end else if (fill) begin
            frames[miss_addr.idx] <= '{valid: 1'b1, tag: miss_addr.tag, data: iload};
        end
    end

`ifdef ICACHE_PERF_EN
    // Performance counters: hits per COMPARE cycle, misses per COMPARE->FETCH transition.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (lookup_hit)
                hit_cnt <= hit_cnt + 32'd1;
            if (state == COMPARE && imemREN && !lookup_hit)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a driver issues fetches and predicts
// hit/miss from a word-address model, a memory responder serves reads
// with random wait states, and a monitor checks every presented word.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q  [$];   // words the monitor expects on ihit, in order
    logic [31:0] miss_q [$];   // addresses the responder expects on iaddr, in order
    int          next_wait;    // wait states for the next memory read

    // Reference model: which word address each of the 16 frames holds.
    bit          mvalid [16];
    logic [29:0] mword  [16];
    int          m_hits;
    int          m_misses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [29:0] w;
        w = a[31:2];
        if (w == 30'h10) return 32'h2001_0005;
        return {w, 2'b00} ^ 32'hA5C3_0F69 ^ {w[14:0], w[29:13]};
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mvalid[a[5:2]] && (mword[a[5:2]] == a[31:2]);
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        mvalid[a[5:2]] = 1'b1;
        mword[a[5:2]]  = a[31:2];
    endfunction

    task automatic check_perf();
`ifdef ICACHE_PERF_EN
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
`endif
    endtask

    // Monitor: every cycle either a hit with the expected word, or imemload=0.
    initial begin
        forever begin
            @(negedge CLK);
            if (ihit) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_hit: actual addr=0x%08h data=0x%08h required no hit", imemaddr, imemload);
                end else begin
                    check("hit_data", imemload, exp_q.pop_front());
                end
            end else begin
                check("load_zero_on_miss", imemload, 32'h0);
            end
        end
    end

    // Memory responder: serves one read per request with next_wait busy cycles.
    initial begin
        bit          in_req = 1'b0;
        int          left   = 0;
        logic [31:0] cur    = '0;
        iwait = 1'b1;
        iload = '0;
        forever begin
            @(negedge CLK);
            if (iREN !== 1'b1) begin
                in_req = 1'b0;
                iwait  = 1'b1;
                iload  = $urandom;
            end else begin
                if (!in_req) begin
                    in_req = 1'b1;
                    left   = next_wait;
                    cur    = iaddr;
                    if (miss_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_fetch: actual iaddr=0x%08h required no read", iaddr);
                    end else begin
                        check("fetch_addr", {iaddr[31:2], 2'b00}, {miss_q.pop_front() >> 2, 2'b00});
                    end
                end else begin
                    check("iaddr_stable", iaddr, cur);
                end
                if (left > 0) begin
                    left--;
                    iwait = 1'b1;
                    iload = $urandom;
                end else begin
                    iwait = 1'b0;
                    iload = mem_word(iaddr);
                end
            end
        end
    end

    // Single fetch: predict hit/miss, then wait for the word (bounded).
    task automatic do_fetch(input logic [31:0] a, input int w);
        bit h;
        int cyc;
        h = model_hit(a);
        next_wait = w;
        if (h) m_hits++;
        else begin
            m_misses++;
            miss_q.push_back(a);
            model_fill(a);
        end
        exp_q.push_back(mem_word(a));
        imemREN  = 1'b1;
        imemaddr = a;
        #1;
        check("hit_now", ihit, h);
        check("iren_idle_on_lookup", iREN, 1'b0);
        cyc = 0;
        while (1) begin
            @(negedge CLK);
            if (ihit || cyc > 40) break;
            cyc++;
        end
        if (!ihit) begin
            check("hit_timeout", ihit, 1'b1);
            exp_q.delete();
        end else begin
            check("latency", cyc, h ? 0 : w + 1);
        end
        #1;
        imemREN = 1'b0;
    endtask

    // Miss on a, then redirect to b while the fill of a is still in flight.
    task automatic do_redirect(input logic [31:0] a, input logic [31:0] b, input int wa, input int wb);
        int cyc;
        m_misses++;
        miss_q.push_back(a);
        model_fill(a);
        next_wait = wa;
        imemREN   = 1'b1;
        imemaddr  = a;
        @(negedge CLK);
        #1;
        check("redirect_in_fetch", iREN, 1'b1);
        imemaddr  = b;
        next_wait = wb;
        m_misses++;
        miss_q.push_back(b);
        model_fill(b);
        exp_q.push_back(mem_word(b));
        cyc = 0;
        while (1) begin
            @(negedge CLK);
            if (ihit || cyc > 60) break;
            cyc++;
        end
        check("redirect_hit", ihit, 1'b1);
        if (!ihit) exp_q.delete();
        #1;
        imemREN = 1'b0;
    endtask

    // Synchronous reset for one edge; outputs must be quiet right after it.
    task automatic do_reset();
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        @(posedge CLK);
        #1;
        check("rst_iren", iREN, 1'b0);
        check("rst_ihit", ihit, 1'b0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_imemload", imemload, 32'h0);
        check_perf();
        @(negedge CLK);
        #1;
        exp_q.delete();
        nRST    = 1'b1;
        imemREN = 1'b0;
    endtask

    task automatic idle(input int n);
        imemREN = 1'b0;
        repeat (n) @(negedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        nRST      = 1'b0;
        imemREN   = 1'b1;
        imemaddr  = 32'h40;
        next_wait = 0;
        @(negedge CLK);
        #1;
        do_reset();

        // Cold miss with 3 wait states, then a same-cycle hit.
        do_fetch(32'h0000_0040, 3);
        idle(3);
        do_fetch(32'h0000_0040, 0);
        check_perf();

        // Conflict on index 0: 0x80 evicts 0x40, which then misses again.
        do_fetch(32'h0000_0080, 1);
        do_fetch(32'h0000_0040, 2);

        // Branch redirect during the fill of 0x44; 0x44 is warm afterwards.
        do_redirect(32'h0000_0044, 32'h0000_0100, 3, 2);
        do_fetch(32'h0000_0044, 0);

        // Warm every frame, abandon a fill with reset, then every frame misses.
        for (int i = 0; i < 16; i++) do_fetch(32'h1000 + i * 4, $urandom_range(0, 2));
        m_misses++;
        miss_q.push_back(32'h2000_0008);
        next_wait = 6;
        imemREN   = 1'b1;
        imemaddr  = 32'h2000_0008;
        @(negedge CLK);
        #1;
        check("fetch_active", iREN, 1'b1);
        do_reset();
        for (int i = 0; i < 16; i++) do_fetch(32'h1000 + i * 4, 0);

        // Randomized fetch stream over a small footprint to mix hits and conflicts.
        for (int n = 0; n < 200; n++) begin
            a = {1'($urandom_range(0, 1)), 23'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            do_fetch(a, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        check_perf();
        idle(2);
        check("miss_q_drained", miss_q.size(), 0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
